led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
Downstream consumer of the half-second divider's square-wave output. It detects rising edges of that wave as step ticks and drives an LED bank with one of four patterns: blink, chase, ping-pong or binary count. It runs for a programmable number of full pattern passes, or until stopped, and reports busy/done to a control FSM or switch logic.

Parameters:
W, 8, LED count; legal 2..16
TICKS_PER_STEP, 1, step rising edges per pattern advance; legal >=1
REPEAT, 4, full pattern passes before done; 0 = run until stop

Ports:
clk  input  1  system clock (CLOCK_50 domain)
aclr  input  1  asynchronous active-low reset
step  input  1  square wave from divider, synchronous to clk; each 0->1 transition is one tick
start  input  1  level, sampled each cycle; begins a run from IDLE
stop  input  1  level, sampled each cycle; aborts a run
mode  input  2  pattern select, captured at start: 0 blink, 1 chase, 2 ping-pong, 3 count
led  output  W  LED drive, registered
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal completion

Behaviour:
- aclr low: all state clears immediately, regardless of clk.
  - Cleared: FSM=IDLE, led=0, busy=0, done=0, step_d=0, prescaler=0, pass count=0, mode_r=0, direction=up.
- Edge detect:
  - step_d <= step every cycle, in every state.
  - tick = step & ~step_d.
  - A level held high for many clocks yields exactly one tick.
- Prescaler counts ticks 0..TICKS_PER_STEP-1.
  - advance = tick & (presc == TICKS_PER_STEP-1); presc then wraps to 0.
  - Latency: led changes on the same clk edge that samples the advancing tick.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - led=0, busy=0.
  - start=1 & stop=0: capture mode into mode_r; load the initial pattern; presc=0, pass=0; go to RUN.
  - Ticks are ignored.
- RUN:
  - busy=1.
  - Priority: stop > advance.
  - stop=1: go to IDLE next edge, led=0, no done pulse.
  - start and mode are ignored.
- DONE: led=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start=1 & stop=1 in IDLE: stay in IDLE.
- Patterns, with initial value and pass length in advances:
  - mode 0 blink: initial all ones; advance inverts led; pass = 2.
  - mode 1 chase: initial 1 (bit0); rotate left, bit W-1 wraps to bit0; pass = W.
  - mode 2 ping-pong: initial bit0, direction up.
    - Shift left until bit W-1 is set, then reverse.
    - Shift right until bit0 is set, then reverse.
    - Reversal happens on the advance that reaches an end, with no dwell at the end.
    - pass = 2W-2.
  - mode 3 count: initial 0; led+1 mod 2^W; pass = 2^W.
- Pass completion occurs when an advance returns led to the initial value (ping-pong: bit0 with direction up).
  - The pass counter increments, width clog2(REPEAT+1).
  - REPEAT!=0 and the count reaches REPEAT: that advance goes to DONE with led=0, and the initial pattern is not redisplayed.
  - REPEAT=0: the pass counter is held and the run wraps forever.
- A tick coincident with start in IDLE is not counted.
- A new start is accepted in IDLE one cycle after a DONE pulse.

Test Plan:
- Reset: hold aclr=0 with random step/start/mode -> led=0, busy=0, done=0. Pull aclr low mid-run -> outputs zero without waiting for a clk edge.
- Chase, W=8, TPS=1, REPEAT=1: start with mode=1 -> led=0x01, busy=1.
  - Ticks 1..7 -> led 0x02,0x04,...,0x80.
  - Tick 8 -> led=0, done=1 for one cycle, busy=0.
- Ping-pong, W=4, REPEAT=2, mode=2: ticks -> led 2,4,8,4,2,1,2,4,8,4,2, then on tick 12 done pulses and led=0.
- Prescale/level: TPS=3, step held high for 50 clks per half-period.
  - led advances only on every third rising edge.
  - Holding step high produces no extra advances.
  - Blink mode: 0xFF, then 0x00 after 3 edges, then 0xFF.
- Control priority:
  - stop at tick 3 of chase -> IDLE, led=0, no done.
  - start&stop together in IDLE -> stays IDLE.
  - start or a mode change during RUN -> ignored; pattern unchanged.
- Count, W=4, REPEAT=0: 40 ticks -> led = 40 mod 16 = 8, busy stays 1, done is never asserted.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pattern_sequencer_if: control/LED bundle for the sequencer      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface led_pattern_sequencer_if #(
  parameter int W = 8
);
  logic         step;
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic         busy;
  logic         done;

  modport master (output step, start, stop, mode, input led, busy, done);
  modport slave  (input step, start, stop, mode, output led, busy, done);
endinterface
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_pattern_sequencer: tick-driven blink/chase/ping-pong/count LEDs |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_pattern_sequencer #(
  parameter int W              = 8,
  parameter int TICKS_PER_STEP = 1,
  parameter int REPEAT         = 4
) (
  input  logic                   clk,
  input  logic                   aclr,
  led_pattern_sequencer_if.slave bus
);

  localparam int PW    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int PASSW = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;

  localparam logic [PW-1:0]    C_PRESC_LAST = PW'(TICKS_PER_STEP - 1);
  localparam logic [PASSW-1:0] C_PASS_LAST  = (REPEAT > 0) ? PASSW'(REPEAT - 1) : '0;

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  localparam logic [1:0] C_MODE_BLINK    = 2'd0;
  localparam logic [1:0] C_MODE_CHASE    = 2'd1;
  localparam logic [1:0] C_MODE_PINGPONG = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     led_q,   led_d;
  logic [1:0]       mode_q,  mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [PASSW-1:0] pass_q,  pass_d;
  logic             dir_q,   dir_d;
  logic             step_q,  step_d;

  logic             w_tick;
  logic             w_advance;
  logic [W-1:0]     w_nxt;
  logic             w_nxt_dir;
  logic             w_wrap;

  function automatic logic [W-1:0] init_pat(input logic [1:0] m);
    case (m)
      C_MODE_BLINK:                  return '1;
      C_MODE_CHASE, C_MODE_PINGPONG: return W'(1);
      default:                       return '0;
    endcase
  endfunction

  assign step_d    = bus.step;
  assign w_tick    = bus.step & ~step_q;
  assign w_advance = w_tick && (presc_q == C_PRESC_LAST);

  // Next pattern value; w_wrap flags a return to the initial pattern.
  // dir_q = 1 means the ping-pong dot is moving toward bit0.
  always_comb begin
    w_nxt     = led_q;
    w_nxt_dir = dir_q;
    w_wrap    = 1'b0;
    case (mode_q)
      C_MODE_BLINK: begin
        w_nxt  = ~led_q;
        w_wrap = (led_q == '0);
      end
      C_MODE_CHASE: begin
        w_nxt  = {led_q[W-2:0], led_q[W-1]};
        w_wrap = (led_q[W-1] == 1'b1);
      end
      C_MODE_PINGPONG: begin
        if (!dir_q) begin
          w_nxt     = led_q << 1;
          w_nxt_dir = led_q[W-2];
        end else begin
          w_nxt     = led_q >> 1;
          w_nxt_dir = ~led_q[1];
          w_wrap    = led_q[1];
        end
      end
      default: begin
        w_nxt  = led_q + W'(1);
        w_wrap = (led_q == '1);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    case (state_q)
      C_ST_IDLE: begin
        led_d = '0;
        if (bus.start && !bus.stop) begin
          mode_d  = bus.mode;
          led_d   = init_pat(bus.mode);
          presc_d = '0;
          pass_d  = '0;
          dir_d   = 1'b0;
          state_d = C_ST_RUN;
        end
      end
      C_ST_RUN: begin
        if (bus.stop) begin
          led_d   = '0;
          state_d = C_ST_IDLE;
        end else begin
          if (w_tick) begin
            presc_d = w_advance ? '0 : presc_q + PW'(1);
          end
          if (w_advance) begin
            led_d = w_nxt;
            dir_d = w_nxt_dir;
            if (w_wrap && (REPEAT != 0)) begin
              if (pass_q == C_PASS_LAST) begin
                led_d   = '0;
                state_d = C_ST_DONE;
              end else begin
                pass_d = pass_q + PASSW'(1);
              end
            end
          end
        end
      end
      default: begin
        led_d   = '0;
        state_d = C_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= C_ST_IDLE;
      led_q   <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = (state_q == C_ST_RUN);
  assign bus.done = (state_q == C_ST_DONE);

endmodule
`default_nettype wire
